mem_arbiter: RTL and testbench

//  Shares the single-port unified word memory between two requesters: port C (multicycle CPU datapath)
//  and port D (debug/program loader). Latches one request, drives the memory for exactly one cycle,

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_if.sv | 26 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port unified memory arbiter.
// Port and state encodings are used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_C,
    PORT_D
  } arb_port_t;

  localparam arb_port_t MEM_ARB_RESET_LAST = PORT_D;

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side bus of the memory arbiter: one instance per port.
// master = requester (CPU or loader), slave = arbiter.
interface mem_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, ack, err, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, ack, err, rdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-way request pick. MEM_ARB_ROUND_ROBIN_EN selects round robin
// against the last granted port; otherwise C has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      c_req,
  input  logic      d_req,
  input  arb_port_t last,
  output arb_port_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = PORT_C;
    unique case (1'b1)
      (c_req && d_req):
        winner = (last == PORT_C) ? PORT_D : PORT_C;
      (d_req && !c_req):
        winner = PORT_D;
      default:
        winner = PORT_C;
    endcase
  end
`else
  logic unused_last;

  assign unused_last = last;
  assign winner = (d_req && !c_req) ? PORT_D : PORT_C;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between ports C and D.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin on simultaneous requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 129
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arb_if.slave          c,
  mem_arb_if.slave          d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  arb_port_t         owner_q, last_q;
  arb_port_t         win, src;
  logic              load;
  logic              own_req;
  logic              we_q, lock_q, inr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              s_we, s_lock;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              in_acc, in_resp;
  logic              c_own, c_ack_w, d_ack_w;

  mem_arb_pick u_pick (
    .c_req  (c.req),
    .d_req  (d.req),
    .last   (last_q),
    .winner (win)
  );

  assign own_req = (owner_q == PORT_C) ? c.req : d.req;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    src     = win;
    unique case (state_q)
      IDLE: begin
        if (c.req || d.req) begin
          load    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        src = owner_q;
        if (lock_q && own_req) begin
          load    = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_we    = (src == PORT_C) ? c.we    : d.we;
  assign s_lock  = (src == PORT_C) ? c.lock  : d.lock;
  assign s_addr  = (src == PORT_C) ? c.addr  : d.addr;
  assign s_wdata = (src == PORT_C) ? c.wdata : d.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_C;
      last_q  <= MEM_ARB_RESET_LAST;
      we_q    <= 1'b0;
      lock_q  <= 1'b0;
      inr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= src;
        last_q  <= src;
        we_q    <= s_we;
        lock_q  <= s_lock;
        inr_q   <= s_addr < ADDR_W'(MEM_DEPTH);
        addr_q  <= s_addr;
        wdata_q <= s_wdata;
      end
      if (state_q == ACCESS)
        rdata_q <= (!we_q && inr_q) ? mem_rdata : '0;
    end
  end

  // Everything the memory and requesters see is decoded from state
  assign in_acc  = (state_q == ACCESS);
  assign in_resp = (state_q == RESP);
  assign c_own   = (owner_q == PORT_C);
  assign c_ack_w = in_resp && c_own;
  assign d_ack_w = in_resp && !c_own;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = in_acc && we_q && inr_q;
  assign mem_re    = in_acc && !we_q && inr_q;

  assign c.gnt   = in_acc && c_own;
  assign d.gnt   = in_acc && !c_own;
  assign c.ack   = c_ack_w;
  assign d.ack   = d_ack_w;
  assign c.err   = c_ack_w && !inr_q;
  assign d.err   = d_ack_w && !inr_q;
  assign c.rdata = c_ack_w ? rdata_q : '0;
  assign d.rdata = d_ack_w ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level memory model.
module tb_mem_arbiter;
  localparam int DEPTH = 129;

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic        tb_init;

  mem_arb_if #(.DATA_W(32), .ADDR_W(32)) c_if ();
  mem_arb_if #(.DATA_W(32), .ADDR_W(32)) d_if ();

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c         (c_if),
    .d         (d_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] seed(int i);
    if (i == 24) return 32'h10;
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0097);
  endfunction

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
    end else if (mem_we && mem_addr < DEPTH) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr < DEPTH) mem_rdata = mem[mem_addr[7:0]];
  end

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  txn_t q [2][$];
  exp_t pend [2][$];
  int   glog[$];
  int   gcyc[$];
  int   ack_log [2][$];
  int   req_cyc [2];
  logic req_on [2];
  logic [31:0] last_rdata [2];
  logic last_err [2];
  int   we_cnt = 0;
  int   acc_cnt = 0;
  int   ack_cnt [2];
  logic abort_armed = 0;
  logic abort_done = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic drive(int p, logic r, txn_t t);
    if (p == 0) begin
      c_if.req = r; c_if.we = t.we; c_if.lock = t.lock;
      c_if.addr = t.addr; c_if.wdata = t.wdata;
    end else begin
      d_if.req = r; d_if.we = t.we; d_if.lock = t.lock;
      d_if.addr = t.addr; d_if.wdata = t.wdata;
    end
  endtask

  task automatic step();
    logic g [2];
    logic a [2];
    logic er [2];
    logic [31:0] rd [2];
    logic exp_ack, inr;
    txn_t t, idle_t;
    exp_t e;
    cyc++;
    g[0] = c_if.gnt;  g[1] = d_if.gnt;
    a[0] = c_if.ack;  a[1] = d_if.ack;
    er[0] = c_if.err; er[1] = d_if.err;
    rd[0] = c_if.rdata; rd[1] = d_if.rdata;
    if (mem_we || mem_re) check("we_re_excl", 32'(mem_we && mem_re), 0);
    if (g[0] || g[1]) check("gnt_excl", 32'(g[0] && g[1]), 0);
    if (mem_we) we_cnt++;
    if (mem_we || mem_re) acc_cnt++;
    for (int p = 0; p < 2; p++) begin
      if (a[p]) ack_cnt[p]++;
      exp_ack = pend[p].size() > 0 && pend[p][0].cyc + 1 == cyc;
      if (a[p] || exp_ack) begin
        check("ack", 32'(a[p]), 32'(exp_ack));
        if (exp_ack) begin
          e = pend[p].pop_front();
          if (a[p]) begin
            check("rdata", rd[p], e.rdata);
            check("err", 32'(er[p]), 32'(e.err));
            last_rdata[p] = rd[p];
            last_err[p] = er[p];
            ack_log[p].push_back(cyc);
          end
        end
      end
      if (g[p]) begin
        if (q[p].size() == 0) begin
          check("gnt_spurious", 32'(g[p]), 0);
        end else begin
          t = q[p][0];
          inr = t.addr < DEPTH;
          if (abort_armed && p == 0 && t.we) begin
            check("t6_we_pre", 32'(mem_we), 1);
            rst_n = 0;
            #1;
            check("t6_we_drop", 32'(mem_we), 0);
            check("t6_gnt_drop", 32'(c_if.gnt), 0);
            abort_armed = 0;
            abort_done = 1;
            void'(q[p].pop_front());
          end else begin
            check("mem_addr", mem_addr, t.addr);
            check("mem_we", 32'(mem_we), 32'(t.we && inr));
            check("mem_re", 32'(mem_re), 32'(!t.we && inr));
            if (t.we && inr) check("mem_wdata", mem_wdata, t.wdata);
            e.cyc = cyc;
            e.err = !inr;
            e.rdata = (!t.we && inr) ? ref_mem[t.addr[7:0]] : 32'h0;
            if (t.we && inr) ref_mem[t.addr[7:0]] = t.wdata;
            pend[p].push_back(e);
            glog.push_back(p);
            gcyc.push_back(cyc);
            void'(q[p].pop_front());
          end
        end
      end
    end
    idle_t = '{we: 0, lock: 0, addr: 0, wdata: 0};
    for (int p = 0; p < 2; p++) begin
      if (q[p].size() > 0) begin
        if (!req_on[p]) req_cyc[p] = cyc;
        req_on[p] = 1;
        drive(p, 1, q[p][0]);
      end else begin
        req_on[p] = 0;
        drive(p, 0, idle_t);
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_on[p] = 0; req_cyc[p] = 0; ack_cnt[p] = 0;
      last_rdata[p] = 0; last_err[p] = 0;
    end
    forever begin
      @(negedge clk);
      step();
    end
  end

  function automatic txn_t mk(logic we, logic lock, logic [31:0] a,
                              logic [31:0] wd);
    txn_t t;
    t.we = we; t.lock = lock; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  task automatic drain();
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || pend[0].size() > 0 ||
            pend[1].size() > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    ack_log[0].delete();
    ack_log[1].delete();
  endtask

  initial begin
    int exp_p, cnt;
    logic [31:0] old;
    txn_t t;
    rst_n = 0;
    tb_init = 1;
    c_if.req = 0; c_if.we = 0; c_if.lock = 0; c_if.addr = 0; c_if.wdata = 0;
    d_if.req = 0; d_if.we = 0; d_if.lock = 0; d_if.addr = 0; d_if.wdata = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
    repeat (3) @(posedge clk);
    tb_init = 0;
    #1;
    check("rst_c_gnt", 32'(c_if.gnt), 0);
    check("rst_d_gnt", 32'(d_if.gnt), 0);
    check("rst_c_ack", 32'(c_if.ack), 0);
    check("rst_d_ack", 32'(d_if.ack), 0);
    check("rst_c_err", 32'(c_if.err), 0);
    check("rst_c_rdata", c_if.rdata, 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #2 rst_n = 1;

    // simultaneous requests straight out of reset
    @(posedge clk);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q[0].push_back(mk(0, 0, 32'(10 + i), 0));
      q[1].push_back(mk(0, 0, 32'(50 + i), 0));
    end
    drain();
    check("t3_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_p = i % 2;
`else
      exp_p = (i >= 4) ? 1 : 0;
`endif
      check("t3_order", glog[i], exp_p);
    end

    // single read and latency
    clear_logs();
    @(posedge clk);
    q[0].push_back(mk(0, 0, 24, 0));
    drain();
    if (gcyc.size() > 0) check("t1_gnt_lat", gcyc[0] - req_cyc[0], 1);
    else check("t1_no_gnt", 0, 1);
    check("t1_rdata", last_rdata[0], 32'h10);
    check("t1_err", 32'(last_err[0]), 0);

    // D write then C read back
    we_cnt = 0;
    @(posedge clk);
    q[1].push_back(mk(1, 0, 30, 32'hDEAD_BEEF));
    drain();
    check("t2_we_cycles", we_cnt, 1);
    q[0].push_back(mk(0, 0, 30, 0));
    drain();
    check("t2_rdata", last_rdata[0], 32'hDEAD_BEEF);

    // locked burst from C while D waits
    clear_logs();
    @(posedge clk);
    for (int i = 0; i < 3; i++) q[0].push_back(mk(0, 1, 32'(5 + i), 0));
    @(posedge clk);
    q[1].push_back(mk(0, 0, 8, 0));
    drain();
    check("t4_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      check("t4_order", glog[i], (i == 3) ? 1 : 0);
    check("t4_acks", ack_log[0].size(), 3);
    for (int i = 1; i < ack_log[0].size(); i++)
      check("t4_ack_gap", ack_log[0][i] - ack_log[0][i-1], 2);

    // out of range read
    acc_cnt = 0;
    last_rdata[1] = 32'hFFFF_FFFF;
    last_err[1] = 0;
    @(posedge clk);
    q[1].push_back(mk(0, 0, 200, 0));
    drain();
    check("t5_mem_access", acc_cnt, 0);
    check("t5_err", 32'(last_err[1]), 1);
    check("t5_rdata", last_rdata[1], 0);

    // reset in the middle of a C write
    old = ref_mem[40];
    cnt = ack_cnt[0];
    abort_done = 0;
    abort_armed = 1;
    @(posedge clk);
    q[0].push_back(mk(1, 0, 40, 32'h1234_5678));
    for (int i = 0; i < 50 && !abort_done; i++) @(posedge clk);
    check("t6_abort_seen", 32'(abort_done), 1);
    abort_armed = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (3) @(posedge clk);
    check("t6_no_ack", ack_cnt[0], cnt);
    check("t6_word", mem[40], old);
    q[0].push_back(mk(0, 0, 40, 0));
    drain();
    check("t6_readback", last_rdata[0], old);

    // randomized traffic on both ports
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) == 0 && q[p].size() < 2) begin
          t.we = 1'($urandom_range(0, 1));
          t.lock = ($urandom_range(0, 3) == 0);
          t.addr = ($urandom_range(0, 9) == 0) ? $urandom
                                               : 32'($urandom_range(0, 140));
          t.wdata = $urandom;
          q[p].push_back(t);
        end
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
